// File: rtl/ctl_score_bcd.sv
// N-digit BCD score accumulator: digit-serial adder with a one-deep hit buffer,
// saturate or wrap on overflow, and a high-score register.
module ctl_score_bcd #(
   parameter int DIGITS   = 4,
   parameter bit SATURATE = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                reset_score,
   input  logic                hit,
   input  logic [3:0]          points,
   output logic [4*DIGITS-1:0] score_bcd,
   output logic [4*DIGITS-1:0] high_bcd,
   output logic                busy,
   output logic                new_high,
   output logic                overflow,
   output logic                hit_dropped
);

   localparam int W  = 4 * DIGITS;
   localparam int IW = $clog2(DIGITS);
   localparam logic [IW-1:0] LAST_IDX  = IW'(DIGITS - 1);
   localparam logic [W-1:0]  ALL_NINES = {DIGITS{4'h9}};

   typedef enum logic [1:0] {
      S_IDLE,
      S_ADD,
      S_COMMIT
   } state_t;

   state_t        state;
   state_t        state_nxt;

   logic [W-1:0]  work;
   logic [3:0]    addend;
   logic [IW-1:0] idx;
   logic          carry;
   logic          pend_valid;
   logic [3:0]    pend_pts;

   logic [3:0]    clamped;
   logic [3:0]    cur_digit;
   logic [4:0]    digit_sum;
   logic [3:0]    digit_nxt;
   logic [W-1:0]  commit_val;

   assign busy = (state != S_IDLE);

   // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      clamped    = (points > 4'd9) ? 4'd9 : points;
      cur_digit  = work[{idx, 2'b00} +: 4];
      digit_sum  = 5'(cur_digit) + 5'((idx == '0) ? addend : 4'd0) + 5'(carry);
      digit_nxt  = (digit_sum > 5'd9) ? 4'(digit_sum - 5'd10) : digit_sum[3:0];
      commit_val = (carry && SATURATE) ? ALL_NINES : work;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (hit || pend_valid) state_nxt = S_ADD;
         S_ADD:    if (idx == LAST_IDX) state_nxt = S_COMMIT;
         S_COMMIT: state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
      if (reset_score) state_nxt = S_IDLE;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         work        <= '0;
         addend      <= '0;
         idx         <= '0;
         carry       <= 1'b0;
         pend_valid  <= 1'b0;
         pend_pts    <= '0;
         score_bcd   <= '0;
         high_bcd    <= '0;
         new_high    <= 1'b0;
         overflow    <= 1'b0;
         hit_dropped <= 1'b0;
      end else if (reset_score) begin
         // In-flight work is simply abandoned; the next start reloads it.
         score_bcd   <= '0;
         overflow    <= 1'b0;
         pend_valid  <= 1'b0;
         new_high    <= 1'b0;
         hit_dropped <= 1'b0;
      end else begin
         new_high    <= 1'b0;
         hit_dropped <= 1'b0;
         case (state)
            S_IDLE: begin
               if (pend_valid || hit) begin
                  addend <= pend_valid ? pend_pts : clamped;
                  work   <= score_bcd;
                  idx    <= '0;
                  carry  <= 1'b0;
               end
               // A hit landing on the cycle the buffer drains refills it.
               if (pend_valid) begin
                  pend_valid <= hit;
                  pend_pts   <= clamped;
               end
            end
            S_ADD: begin
               work[{idx, 2'b00} +: 4] <= digit_nxt;
               carry                   <= (digit_sum > 5'd9);
               idx                     <= idx + IW'(1);
            end
            S_COMMIT: begin
               score_bcd <= commit_val;
               if (carry) overflow <= 1'b1;
               if (commit_val > high_bcd) begin
                  high_bcd <= commit_val;
                  new_high <= 1'b1;
               end
            end
            default: ;
         endcase
         if (busy && hit) begin
            if (pend_valid) begin
               hit_dropped <= 1'b1;
            end else begin
               pend_valid <= 1'b1;
               pend_pts   <= clamped;
            end
         end
      end
   end

endmodule
